key_delivery_unit: RTL and testbench

// - Other end of the locked netlists' keyIn_0_* bus: receives a serial key frame, checks it and drives the key bus.
// - Sits between the test/provisioning serial port and a locked core (e.g. a 16-key rll16 circuit).
// - Drives the key outputs only after a parity-checked frame.
// - Key is optionally write-once until reset.

---
 rtl/keydel_pkg.sv | 18 +
 rtl/key_shift_reg.sv | 57 +++++
 rtl/key_delivery_unit.sv | 122 ++++++++++++
 tb/tb_key_delivery_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keydel_pkg.sv
// rtl/keydel_pkg.sv - shared types and sizing helpers for the key delivery unit
package keydel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        LOADED = 2'd3
    } state_e;

    localparam int KEY_WIDTH_DEF = 16;

    // One even-parity bit trails the key in every frame.
    function automatic int frame_len(input int kw);
        return kw + 1;
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// rtl/key_shift_reg.sv - serial frame shift register with bit counter and running parity
module key_shift_reg
    import keydel_pkg::*;
#(
    parameter int FRAME_LEN = frame_len(KEY_WIDTH_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 sdi,
    output logic [FRAME_LEN-2:0] key_bits,
    output logic                 last_bit,
    output logic                 done,
    output logic                 par_ok
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;

    // clear has priority so a restart in the same cycle drops the presented bit
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[FRAME_LEN-2:0], sdi};
            cnt_d   = cnt_q + 1'b1;
            par_d   = par_q ^ sdi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    assign key_bits = shreg_q[FRAME_LEN-1:1];
    assign last_bit = (cnt_q == CW'(FRAME_LEN - 1));
    assign done     = (cnt_q == CW'(FRAME_LEN));
    assign par_ok   = ~par_q;

endmodule

// File: rtl/key_delivery_unit.sv
// rtl/key_delivery_unit.sv - receives a parity-checked serial key frame and drives the locked core key bus
module key_delivery_unit
    import keydel_pkg::*;
#(
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter bit                   LOCK_ONCE = 1'b1,
    parameter logic [KEY_WIDTH-1:0] RESET_KEY = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 sdi_valid,
    input  logic                 sdi,
    output logic                 sdi_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 key_err,
    output logic                 busy
);

    localparam int FRAME_LEN = frame_len(KEY_WIDTH);

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_err_q, key_err_d;
    logic                 sdi_ready_q, sdi_ready_d;
    logic                 busy_q, busy_d;

    logic                 clear, shift_en;
    logic [KEY_WIDTH-1:0] key_bits;
    logic                 last_bit, done, par_ok;

    key_shift_reg #(
        .FRAME_LEN (FRAME_LEN)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .shift_en (shift_en),
        .sdi      (sdi),
        .key_bits (key_bits),
        .last_bit (last_bit),
        .done     (done),
        .par_ok   (par_ok)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;
        clear       = 1'b0;
        shift_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = SHIFT;
                    clear     = 1'b1;
                    key_err_d = 1'b0;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    clear     = 1'b1;
                    key_err_d = 1'b0;
                end else if (sdi_valid) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (done && par_ok) begin
                    key_d       = key_bits;
                    key_valid_d = 1'b1;
                    state_d     = LOADED;
                end else begin
                    key_err_d = 1'b1;
                    state_d   = key_valid_q ? LOADED : IDLE;
                end
            end
            LOADED: begin
                // The held key stays on the bus through a reload until a good CHECK replaces it.
                if (!LOCK_ONCE && frame_start) begin
                    state_d   = SHIFT;
                    clear     = 1'b1;
                    key_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        sdi_ready_d = (state_d == SHIFT);
        busy_d      = (state_d == SHIFT) || (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= RESET_KEY;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            sdi_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            sdi_ready_q <= sdi_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign sdi_ready = sdi_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_key_delivery_unit.sv
// tb/tb_key_delivery_unit.sv - randomized bench for key_delivery_unit, both LOCK_ONCE settings side by side
module tb_key_delivery_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        sdi_valid = 1'b0;
    logic        sdi = 1'b0;

    logic        rdy0, kv0, ke0, bz0;
    logic        rdy1, kv1, ke1, bz1;
    logic [15:0] key0, key1;

    logic [19:0] obs [2];
    assign obs[0] = {key0, kv0, ke0, bz0, rdy0};
    assign obs[1] = {key1, kv1, ke1, bz1, rdy1};

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 is the reloadable unit, index 1 the write-once unit.
    logic [15:0] m_key    [2];
    bit          m_valid  [2];
    bit          m_err    [2];
    bit          m_active [2];

    always #5 clk = ~clk;

    key_delivery_unit #(.KEY_WIDTH(16), .LOCK_ONCE(1'b0), .RESET_KEY(16'h0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sdi_valid(sdi_valid), .sdi(sdi),
        .sdi_ready(rdy0), .key_out(key0), .key_valid(kv0), .key_err(ke0), .busy(bz0)
    );

    key_delivery_unit #(.KEY_WIDTH(16), .LOCK_ONCE(1'b1), .RESET_KEY(16'h0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sdi_valid(sdi_valid), .sdi(sdi),
        .sdi_ready(rdy1), .key_out(key1), .key_valid(kv1), .key_err(ke1), .busy(bz1)
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_key[i] = 16'h0000; m_valid[i] = 0; m_err[i] = 0; m_active[i] = 0;
        end
    endfunction

    function automatic void model_start();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = !(i == 1 && m_valid[1]);
            if (m_active[i]) m_err[i] = 0;
        end
    endfunction

    function automatic void model_finish(input logic [15:0] data, input logic par);
        for (int i = 0; i < 2; i++) begin
            if (m_active[i]) begin
                if ((^{data, par}) == 1'b0) begin
                    m_key[i] = data; m_valid[i] = 1;
                end else begin
                    m_err[i] = 1;
                end
                m_active[i] = 0;
            end
        end
    endfunction

    // ph: 0 settled, 1 shifting, 2 checking (last bit taken, result not yet visible)
    function automatic logic [19:0] exp_vec(input int i, input int ph);
        if (!m_active[i] || ph == 0) return {m_key[i], m_valid[i], m_err[i], 2'b00};
        if (ph == 1) return {m_key[i], m_valid[i], 1'b0, 2'b11};
        return {m_key[i], m_valid[i], 1'b0, 2'b10};
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1; sdi_valid = 1'b1; sdi = 1'($urandom);
        @(negedge clk);
        frame_start = 1'b0; sdi_valid = 1'b0;
        model_start();
    endtask

    task automatic shift_bits(input logic [16:0] bits, input int n, input bit gaps);
        for (int i = 16; i > 16 - n; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sdi_valid = 1'b0; sdi = 1'($urandom);
                    @(negedge clk);
                end
            end
            sdi_valid = 1'b1; sdi = bits[i];
            @(negedge clk);
            sdi_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input logic par, input bit gaps);
        start_frame();
        shift_bits({data, par}, 17, gaps);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== 20'h0) begin
                bad++; $display("FAIL reset dut%0d got=%h exp=%h", i, obs[i], 20'h0);
            end
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_good_frame();
        send_frame(16'hA5C3, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 2)) begin
                bad++; $display("FAIL good_latency dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 2));
            end
        end
        @(negedge clk);
        model_finish(16'hA5C3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 0)) begin
                bad++; $display("FAIL good_load dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 0));
            end
        end
        total++;
        if ({key0, kv0, ke0} !== {16'hA5C3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL good_key got=%h exp=%h", {key0, kv0, ke0}, {16'hA5C3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_bad_parity();
        do_reset();
        send_frame(16'hA5C3, 1'b1, 1'b0);
        @(negedge clk);
        model_finish(16'hA5C3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 0)) begin
                bad++; $display("FAIL bad_parity dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 0));
            end
        end
        total++;
        if ({key1, kv1, ke1, bz1, rdy1} !== {16'h0000, 4'b0100}) begin
            bad++; $display("FAIL bad_parity_const got=%h exp=%h", obs[1], {16'h0000, 4'b0100});
        end
        start_frame();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 1)) begin
                bad++; $display("FAIL err_clear dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 1));
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        send_frame(16'hA5C3, 1'b0, 1'b1);
        @(negedge clk);
        model_finish(16'hA5C3, 1'b0);
        send_frame(16'h1234, 1'b1, 1'b1);
        // frame_start while in CHECK must not restart the frame
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        model_finish(16'h1234, 1'b1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 0)) begin
                bad++; $display("FAIL lock dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 0));
            end
        end
        total++;
        if ({key0, key1} !== {16'h1234, 16'hA5C3}) begin
            bad++; $display("FAIL lock_keys got=%h exp=%h", {key0, key1}, {16'h1234, 16'hA5C3});
        end
    endtask

    task automatic test_abort_stall();
        logic [16:0] junk;
        do_reset();
        junk = 17'($urandom);
        start_frame();
        shift_bits(junk, 7, 1'b1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 1)) begin
                bad++; $display("FAIL abort_mid dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 1));
            end
        end
        send_frame(16'h00FF, 1'b0, 1'b1);
        @(negedge clk);
        model_finish(16'h00FF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 0) || obs[i][19:4] !== 16'h00FF) begin
                bad++; $display("FAIL abort_load dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 0));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_frame(16'hA5C3, 1'b0, 1'b0);
        @(negedge clk);
        model_finish(16'hA5C3, 1'b0);
        start_frame();
        shift_bits(17'h1B3C5, 10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== 20'h0) begin
                bad++; $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs[i], 20'h0);
            end
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        send_frame(16'hA5C3, 1'b0, 1'b1);
        @(negedge clk);
        model_finish(16'hA5C3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i, 0)) begin
                bad++; $display("FAIL reload_after_reset dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 0));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] data;
        logic        par;
        logic [16:0] junk;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            data = 16'($urandom);
            par  = ($urandom_range(0, 3) == 0) ? ~(^data) : ^data;
            if ($urandom_range(0, 3) == 0) begin
                junk = 17'($urandom);
                start_frame();
                shift_bits(junk, $urandom_range(1, 16), 1'b1);
            end
            send_frame(data, par, 1'b1);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i, 2)) begin
                    bad++; $display("FAIL rand_check dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 2));
                end
            end
            @(negedge clk);
            model_finish(data, par);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i, 0)) begin
                    bad++; $display("FAIL rand_load dut%0d got=%h exp=%h", i, obs[i], exp_vec(i, 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_lock();
        test_abort_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
